// File: rtl/execute_pipe_pkg.sv
// execute_pipe_pkg: shared widths, writeback-select and state encodings, and the packed EX/MEM payload
package execute_pipe_pkg;
    localparam int XLEN  = 32;
    localparam int RD_HI = 11;
    localparam int RD_LO = 7;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_e;

    typedef struct packed {
        logic            load;
        logic            store;
        logic            next_sel;
        logic [1:0]      mem_to_reg;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] pre_address;
        logic [XLEN-1:0] instruction;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);
endpackage

// File: rtl/execute_pipe_if.sv
// execute_pipe_if: valid/ready stage bus carrying one EX/MEM instruction
//   master drives valid and payload, slave drives ready
interface execute_pipe_if;
    import execute_pipe_pkg::*;
    logic            valid;
    logic            ready;
    logic            load;
    logic            store;
    logic            next_sel;
    logic [1:0]      mem_to_reg;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pre_address;
    logic [XLEN-1:0] instruction;

    modport master (
        output valid, load, store, next_sel, mem_to_reg,
               alu_result, store_data, pre_address, instruction,
        input  ready
    );
    modport slave (
        input  valid, load, store, next_sel, mem_to_reg,
               alu_result, store_data, pre_address, instruction,
        output ready
    );
endinterface

// File: rtl/execute_pipe_skid_entry.sv
// pipe_skid_entry: W-bit payload register with load enable, cleared by async active-low reset
//   clk, rst_n : clock, async active-low reset
//   en         : capture d on the rising edge
//   d / q      : payload in / held payload
module pipe_skid_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= d;
endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: EX/MEM pipeline register with one-entry skid buffer and EX/MEM forwarding taps
//   clk, rst_n  : clock, async active-low reset
//   flush       : synchronous kill of all held entries (redirect)
//   ex_if       : slave side toward EX; ex_if.ready is the registered in_ready
//   mem_if      : master side toward MEM; carries the head (main) entry
//   fwd_rd/we/data/is_load : head destination and value for forwarding / load-use stall
module execute_pipe
    import execute_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    execute_pipe_if.slave         ex_if,
    execute_pipe_if.master        mem_if,
    output logic [RD_HI-RD_LO:0]  fwd_rd,
    output logic                  fwd_we,
    output logic [XLEN-1:0]       fwd_data,
    output logic                  fwd_is_load
);
    state_e   state_q, state_d;
    logic     in_ready_q, in_ready_d;
    logic     accept, pop, main_en, skid_en, main_from_skid;
    payload_t in_p, main_d, main_q, skid_q;

    assign in_p = '{
        load:        ex_if.load,
        store:       ex_if.store,
        next_sel:    ex_if.next_sel,
        mem_to_reg:  ex_if.mem_to_reg,
        alu_result:  ex_if.alu_result,
        store_data:  ex_if.store_data,
        pre_address: ex_if.pre_address,
        instruction: ex_if.instruction
    };

    assign accept = ex_if.valid & in_ready_q;
    assign pop    = mem_if.valid & mem_if.ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: if (accept) begin
                state_d = ST_FULL;
                main_en = 1'b1;
            end
            ST_FULL: if (accept && pop) begin
                main_en = 1'b1;
            end else if (accept) begin
                state_d = ST_SKID;
                skid_en = 1'b1;
            end else if (pop) begin
                state_d = ST_EMPTY;
            end
            ST_SKID: if (pop) begin
                state_d        = ST_FULL;
                main_en        = 1'b1;
                main_from_skid = 1'b1;
            end
            default: state_d = ST_EMPTY;
        endcase
        // Redirect wins over everything; an accept in this cycle is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
        in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end

    assign main_d = main_from_skid ? skid_q : in_p;

    pipe_skid_entry #(.W(PAYLOAD_W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_skid_entry #(.W(PAYLOAD_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (in_p),
        .q     (skid_q)
    );

    assign ex_if.ready        = in_ready_q;
    assign mem_if.valid       = (state_q != ST_EMPTY);
    assign mem_if.load        = main_q.load;
    assign mem_if.store       = main_q.store;
    assign mem_if.next_sel    = main_q.next_sel;
    assign mem_if.mem_to_reg  = main_q.mem_to_reg;
    assign mem_if.alu_result  = main_q.alu_result;
    assign mem_if.store_data  = main_q.store_data;
    assign mem_if.pre_address = main_q.pre_address;
    assign mem_if.instruction = main_q.instruction;

    // Only the head is forwarded; while the skid entry is occupied in_ready is low and ID stalls.
    assign fwd_rd      = main_q.instruction[RD_HI:RD_LO];
    assign fwd_we      = mem_if.valid && (fwd_rd != '0) && (main_q.mem_to_reg != WB_NONE) && !main_q.store;
    assign fwd_data    = (main_q.mem_to_reg == WB_PC4) ? main_q.pre_address : main_q.alu_result;
    assign fwd_is_load = mem_if.valid && (main_q.mem_to_reg == WB_LOAD);
endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed plus randomized stimulus against a 2-deep FIFO reference model
module tb_execute_pipe;
    import execute_pipe_pkg::*;

    typedef struct {
        logic        load, store, next_sel;
        logic [1:0]  m2r;
        logic [31:0] alu, sd, pc4, ins;
    } tx_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  fwd_rd;
    logic        fwd_we, fwd_is_load;
    logic [31:0] fwd_data;

    execute_pipe_if ex();
    execute_pipe_if mem();

    execute_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .ex_if       (ex),
        .mem_if      (mem),
        .fwd_rd      (fwd_rd),
        .fwd_we      (fwd_we),
        .fwd_data    (fwd_data),
        .fwd_is_load (fwd_is_load)
    );

    always #5 clk = ~clk;

    tx_t  q[$];
    tx_t  cur;
    logic cur_v = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic tx_t mk(logic [31:0] alu, logic [1:0] m2r, logic [4:0] rd,
                               logic ld, logic st, logic [31:0] pc4, logic [31:0] sd);
        tx_t t;
        t.load = ld; t.store = st; t.next_sel = 1'b0; t.m2r = m2r;
        t.alu = alu; t.sd = sd; t.pc4 = pc4; t.ins = {20'h0, rd, 7'h13};
        return t;
    endfunction

    function automatic tx_t rnd();
        tx_t t;
        logic [31:0] b;
        b = $urandom();
        t.load = b[0]; t.store = b[1]; t.next_sel = b[2]; t.m2r = b[4:3];
        t.alu = $urandom(); t.sd = $urandom(); t.pc4 = $urandom(); t.ins = $urandom();
        if (b[7:5] == 3'd0) t.ins[11:7] = 5'd0;
        return t;
    endfunction

    task automatic put(logic v, tx_t t);
        cur_v = v; cur = t;
        ex.valid = v; ex.load = t.load; ex.store = t.store; ex.next_sel = t.next_sel;
        ex.mem_to_reg = t.m2r; ex.alu_result = t.alu; ex.store_data = t.sd;
        ex.pre_address = t.pc4; ex.instruction = t.ins;
    endtask

    task automatic compare();
        tx_t  h;
        logic v;
        v = (q.size() > 0);
        h = mk(0, 2'b00, 5'd0, 1'b0, 1'b0, 0, 0);
        h.ins = 32'h0;
        if (v) h = q[0];
        check("out_valid", {31'h0, mem.valid}, {31'h0, v});
        check("in_ready", {31'h0, ex.ready}, {31'h0, q.size() < 2});
        if (v) begin
            check("alu_result", mem.alu_result, h.alu);
            check("store_data", mem.store_data, h.sd);
            check("pre_address", mem.pre_address, h.pc4);
            check("instruction", mem.instruction, h.ins);
            check("ctrl", {27'h0, mem.load, mem.store, mem.next_sel, mem.mem_to_reg},
                  {27'h0, h.load, h.store, h.next_sel, h.m2r});
            check("fwd_rd", {27'h0, fwd_rd}, {27'h0, h.ins[11:7]});
            check("fwd_data", fwd_data, (h.m2r == 2'b10) ? h.pc4 : h.alu);
        end
        check("fwd_we", {31'h0, fwd_we},
              {31'h0, v && h.ins[11:7] != 5'd0 && h.m2r != 2'b11 && !h.store});
        check("fwd_is_load", {31'h0, fwd_is_load}, {31'h0, v && h.m2r == 2'b01});
    endtask

    task automatic step();
        logic pop, acc;
        @(posedge clk);
        pop = (q.size() > 0) && mem.ready;
        acc = cur_v && (q.size() < 2);
        if (!rst_n || flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(cur);
        end
        #1;
        compare();
    endtask

    task automatic zero_check(string tag);
        check({tag, "_valid"}, {31'h0, mem.valid}, 32'h0);
        check({tag, "_ready"}, {31'h0, ex.ready}, 32'h1);
        check({tag, "_alu"}, mem.alu_result, 32'h0);
        check({tag, "_sd"}, mem.store_data, 32'h0);
        check({tag, "_pc4"}, mem.pre_address, 32'h0);
        check({tag, "_ins"}, mem.instruction, 32'h0);
        check({tag, "_ctrl"}, {27'h0, mem.load, mem.store, mem.next_sel, mem.mem_to_reg}, 32'h0);
        check({tag, "_fwd"}, {26'h0, fwd_rd, fwd_we}, 32'h0);
        check({tag, "_fwdl"}, {31'h0, fwd_is_load}, 32'h0);
        check({tag, "_fdata"}, fwd_data, 32'h0);
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        q.delete();
        zero_check("arst");
        #2 rst_n = 1'b1;
    endtask

    initial begin
        tx_t z;
        z = mk(0, 2'b00, 5'd0, 1'b0, 1'b0, 0, 0);
        put(1'b0, z);
        mem.ready = 1'b1;
        #1 rst_n = 1'b0;
        #2 zero_check("reset");
        #9 rst_n = 1'b1;

        put(1'b1, mk(32'h10, 2'b00, 5'd1, 1'b0, 1'b0, 32'h4, 0)); step();
        check("b2b_first", mem.alu_result, 32'h10);
        put(1'b1, mk(32'h20, 2'b00, 5'd2, 1'b0, 1'b0, 32'h8, 0)); step();
        check("b2b_second", mem.alu_result, 32'h20);
        put(1'b1, mk(32'h30, 2'b00, 5'd3, 1'b0, 1'b0, 32'hc, 0)); step();
        check("b2b_third", mem.alu_result, 32'h30);
        put(1'b0, z); step(); step();

        mem.ready = 1'b0;
        put(1'b1, mk(32'hA, 2'b00, 5'd4, 1'b0, 1'b0, 0, 0)); step();
        put(1'b1, mk(32'hB, 2'b00, 5'd4, 1'b0, 1'b0, 0, 0)); step();
        check("skid_ready", {31'h0, ex.ready}, 32'h0);
        check("skid_hold", mem.alu_result, 32'hA);
        put(1'b1, mk(32'hD, 2'b00, 5'd4, 1'b0, 1'b0, 0, 0)); step();
        mem.ready = 1'b1; put(1'b0, z); step();
        check("drain_b", mem.alu_result, 32'hB);
        step();

        mem.ready = 1'b0;
        put(1'b1, mk(32'hA, 2'b00, 5'd4, 1'b0, 1'b0, 0, 0)); step();
        put(1'b1, mk(32'hB, 2'b00, 5'd4, 1'b0, 1'b0, 0, 0)); step();
        flush = 1'b1; put(1'b1, mk(32'hC, 2'b00, 5'd4, 1'b0, 1'b0, 0, 0)); step();
        flush = 1'b0;
        check("flush_valid", {31'h0, mem.valid}, 32'h0);
        check("flush_ready", {31'h0, ex.ready}, 32'h1);
        mem.ready = 1'b1; put(1'b0, z); step();

        put(1'b1, mk(32'h55, 2'b10, 5'd5, 1'b0, 1'b0, 32'h104, 0)); step();
        check("fwd_x5_rd", {27'h0, fwd_rd}, 32'd5);
        check("fwd_x5_we", {31'h0, fwd_we}, 32'h1);
        check("fwd_x5_data", fwd_data, 32'h104);
        put(1'b1, mk(32'h55, 2'b10, 5'd0, 1'b0, 1'b0, 32'h104, 0)); step();
        check("fwd_x0_we", {31'h0, fwd_we}, 32'h0);
        put(1'b1, mk(32'h200, 2'b01, 5'd7, 1'b1, 1'b0, 32'h108, 0)); step();
        check("fwd_load_is", {31'h0, fwd_is_load}, 32'h1);
        check("fwd_load_we", {31'h0, fwd_we}, 32'h1);
        put(1'b1, mk(32'h300, 2'b11, 5'd9, 1'b0, 1'b1, 32'h10c, 32'hCAFE)); step();
        check("st_we", {31'h0, fwd_we}, 32'h0);
        check("st_store", {31'h0, mem.store}, 32'h1);
        check("st_data", mem.store_data, 32'hCAFE);

        mem.ready = 1'b0;
        put(1'b1, mk(32'hA, 2'b00, 5'd4, 1'b0, 1'b0, 0, 0)); step();
        put(1'b1, mk(32'hB, 2'b00, 5'd4, 1'b0, 1'b0, 0, 0)); step();
        put(1'b0, z);
        async_reset();
        mem.ready = 1'b1;
        put(1'b1, mk(32'hE, 2'b00, 5'd6, 1'b0, 1'b0, 0, 0)); step();
        check("post_rst", mem.alu_result, 32'hE);
        put(1'b0, z); step();

        for (int i = 0; i < 1500; i++) begin
            put($urandom_range(0, 9) < 7, rnd());
            mem.ready = $urandom_range(0, 9) < 6;
            flush = $urandom_range(0, 19) == 0;
            step();
            if ($urandom_range(0, 99) == 0) begin
                flush = 1'b0;
                async_reset();
            end
        end
        flush = 1'b0;
        put(1'b0, z);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
